// File: rtl/fetch.sv
// Instruction fetch stage: credit-limited imem requests, in-order response pairing
// with a PC queue, a 2-entry IF/ID output FIFO, and redirect/discard handling.
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_ex_redirect,
  input  logic [31:0] i_ex_target,
  input  logic        i_dec_jal,
  input  logic [31:0] i_dec_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_flush
);

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  discard_q, discard_d;
  logic [31:0] pcq_q [2];
  logic [31:0] pcq_d [2];
  logic [1:0]  pcq_cnt_q, pcq_cnt_d;
  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_inst_d [2];
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;

  logic        redirect;
  logic [31:0] target;
  logic        credit_ok;
  logic        accept;
  logic        rsp;
  logic        rsp_keep;
  logic        fifo_vld;
  logic        pop;

  assign redirect  = i_ex_redirect | i_dec_jal;
  assign target    = i_ex_redirect ? i_ex_target : i_dec_target;
  // Everything in flight or buffered counts against the two FIFO slots.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < 3'd2;
  assign accept    = o_imem_req & i_imem_ready;
  assign rsp       = i_imem_rvalid && (outst_q != 2'd0);
  assign rsp_keep  = rsp && !redirect && (discard_q == 2'd0);
  assign fifo_vld  = fifo_cnt_q != 2'd0;
  assign pop       = fifo_vld && !i_hold;

  assign o_imem_req  = !i_rst && !redirect && credit_ok;
  assign o_imem_addr = fetch_pc_q;
  assign o_vld       = fifo_vld && !i_rst;
  assign o_inst      = o_vld ? fifo_inst_q[0] : NOP;
  assign o_pc        = o_vld ? fifo_pc_q[0] : 32'h0;
  assign o_nxt_pc    = o_pc + 32'd4;
  assign o_flush     = redirect && !i_rst;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = target;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    outst_d = outst_q + {1'b0, accept} - {1'b0, rsp};

    discard_d = discard_q;
    if (redirect) begin
      discard_d = outst_q - {1'b0, rsp};
    end else if (rsp && discard_q != 2'd0) begin
      discard_d = discard_q - 2'd1;
    end

    pcq_d     = pcq_q;
    pcq_cnt_d = pcq_cnt_q;
    if (rsp_keep) begin
      pcq_d[0]  = pcq_q[1];
      pcq_cnt_d = pcq_cnt_d - 2'd1;
    end
    if (accept) begin
      pcq_d[pcq_cnt_d[0]] = fetch_pc_q;
      pcq_cnt_d           = pcq_cnt_d + 2'd1;
    end
    if (redirect) begin
      pcq_cnt_d = 2'd0;
    end

    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (pop) begin
      fifo_inst_d[0] = fifo_inst_q[1];
      fifo_pc_d[0]   = fifo_pc_q[1];
      fifo_cnt_d     = fifo_cnt_d - 2'd1;
    end
    if (rsp_keep) begin
      fifo_inst_d[fifo_cnt_d[0]] = i_imem_rdata;
      fifo_pc_d[fifo_cnt_d[0]]   = pcq_q[0];
      fifo_cnt_d                 = fifo_cnt_d + 2'd1;
    end
    if (redirect) begin
      fifo_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_ADDR;
      outst_q    <= 2'd0;
      discard_q  <= 2'd0;
      pcq_cnt_q  <= 2'd0;
      fifo_cnt_q <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      pcq_cnt_q  <= pcq_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Payload storage needs no reset; validity lives in the counters.
  always_ff @(posedge i_clk) begin
    pcq_q       <= pcq_d;
    fifo_inst_q <= fifo_inst_d;
    fifo_pc_q   <= fifo_pc_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(rsp_keep && !pop && fifo_cnt_q == 2'd2));
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios followed by a random phase,
// all checked against an instruction-stream model (next expected PC / fetch address).
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_hold;
  logic        i_ex_redirect;
  logic [31:0] i_ex_target;
  logic        i_dec_jal;
  logic [31:0] i_dec_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_vld;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_nxt_pc;
  logic        o_flush;

  always #5 i_clk = ~i_clk;

  fetch #(.RESET_ADDR(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hold(i_hold),
    .i_ex_redirect(i_ex_redirect), .i_ex_target(i_ex_target),
    .i_dec_jal(i_dec_jal), .i_dec_target(i_dec_target),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ready(i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_vld(o_vld), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc), .o_flush(o_flush)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  // Memory model: accepted addresses in order with the cycle they may return.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat_min = 1;
  int          lat_max = 1;
  int          rsp_pct = 100;
  bit          mem_stall = 0;
  bit          force_stale = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] consumed[$];
  logic [31:0] accepted[$];
  logic [31:0] last_acc = 32'h0;
  logic [31:0] wrap_acc_next = 32'h1;
  logic [31:0] wrap_nxt = 32'h1;
  bit          wrap_seen = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: caller has set the inputs at the falling edge.
  task automatic step();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    if (force_stale) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'hDEAD_BEEF;
      force_stale   = 0;
    end else if (!mem_stall && mq_addr.size() > 0 && mq_due[0] <= cyc
                 && $urandom_range(99) < rsp_pct) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
    check32("flush", {31'b0, o_flush}, {31'b0, !i_rst && (i_ex_redirect || i_dec_jal)});
    check32("nxt_pc", o_nxt_pc, o_pc + 32'd4);
    if (i_rst) begin
      check32("rst_req", {31'b0, o_imem_req}, 32'h0);
      check32("rst_vld", {31'b0, o_vld}, 32'h0);
      check32("rst_inst", o_inst, NOP);
      check32("rst_pc", o_pc, 32'h0);
      exp_pc    = 32'h0;
      exp_fetch = 32'h0;
    end else begin
      if (!o_vld) check32("idle_inst", o_inst, NOP);
      if (o_flush) check32("req_on_redirect", {31'b0, o_imem_req}, 32'h0);
      if (o_vld && !i_hold && !o_flush) begin
        check32("pc", o_pc, exp_pc);
        check32("inst", o_inst, mem_word(exp_pc));
        if (o_pc == 32'hFFFF_FFFC) begin
          wrap_seen = 1;
          wrap_nxt  = o_nxt_pc;
        end
        consumed.push_back(o_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (o_imem_req && i_imem_ready) begin
        check32("fetch_addr", o_imem_addr, exp_fetch);
        if (last_acc == 32'hFFFF_FFFC) wrap_acc_next = o_imem_addr;
        last_acc = o_imem_addr;
        accepted.push_back(o_imem_addr);
        mq_addr.push_back(o_imem_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        check32("credit", {31'b0, mq_addr.size() <= 2}, 32'h1);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (o_flush) begin
        exp_pc    = i_ex_redirect ? i_ex_target : i_dec_target;
        exp_fetch = exp_pc;
      end
    end
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  initial begin
    int   mark;
    int   amark;
    logic [31:0] held_pc;
    logic [31:0] held_inst;
    i_rst = 1'b1; i_hold = 1'b0; i_ex_redirect = 1'b0; i_ex_target = 32'h0;
    i_dec_jal = 1'b0; i_dec_target = 32'h0; i_imem_ready = 1'b1;
    i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    @(negedge i_clk);

    // Reset: outputs idle, redirect during reset does not flush.
    i_ex_redirect = 1'b1; i_ex_target = 32'h40;
    step();
    i_ex_redirect = 1'b0;
    step();

    // First request immediately after reset, at RESET_ADDR.
    i_rst = 1'b0;
    #1;
    check32("first_req", {31'b0, o_imem_req}, 32'h1);
    check32("first_addr", o_imem_addr, 32'h0);
    step();
    check32("fill_vld_c1", {31'b0, o_vld}, 32'h0);
    step();
    check32("fill_vld_c2", {31'b0, o_vld}, 32'h1);
    check32("fill_pc_c2", o_pc, 32'h0);
    repeat (10) step();
    check32("stream_pc0", consumed[0], 32'h0);
    check32("stream_pc1", consumed[1], 32'h4);
    check32("stream_pc2", consumed[2], 32'h8);
    check32("stream_pc3", consumed[3], 32'hC);

    // Backpressure: FIFO fills, requests stop, head stays stable.
    i_hold = 1'b1;
    repeat (3) step();
    held_pc   = o_pc;
    held_inst = o_inst;
    repeat (5) begin
      #1;
      check32("bp_req", {31'b0, o_imem_req}, 32'h0);
      check32("bp_vld", {31'b0, o_vld}, 32'h1);
      check32("bp_pc", o_pc, held_pc);
      check32("bp_inst", o_inst, held_inst);
      step();
    end
    i_hold = 1'b0;
    mark = consumed.size();
    repeat (8) step();
    check32("bp_release_pc", consumed[mark], held_pc);

    // Redirect with two requests outstanding.
    mem_stall = 1;
    repeat (6) step();
    #1;
    check32("two_out_req", {31'b0, o_imem_req}, 32'h0);
    check32("two_out_vld", {31'b0, o_vld}, 32'h0);
    i_ex_redirect = 1'b1; i_ex_target = 32'h100;
    step();
    i_ex_redirect = 1'b0;
    mem_stall = 0;
    mark = consumed.size();
    repeat (8) step();
    check32("redir_first_pc", consumed[mark], 32'h100);

    // Redirect while held clears the FIFO.
    i_hold = 1'b1;
    repeat (4) step();
    i_dec_jal = 1'b1; i_dec_target = 32'h180;
    step();
    i_dec_jal = 1'b0;
    #1;
    check32("hold_redir_vld", {31'b0, o_vld}, 32'h0);
    i_hold = 1'b0;
    mark = consumed.size();
    repeat (8) step();
    check32("hold_redir_pc", consumed[mark], 32'h180);

    // EX redirect wins over a simultaneous decode jal.
    i_ex_redirect = 1'b1; i_ex_target = 32'h200;
    i_dec_jal = 1'b1; i_dec_target = 32'h300;
    amark = accepted.size();
    mark  = consumed.size();
    step();
    i_ex_redirect = 1'b0; i_dec_jal = 1'b0;
    repeat (8) step();
    check32("prio_addr", accepted[amark], 32'h200);
    check32("prio_pc", consumed[mark], 32'h200);

    // Address wrap.
    i_dec_jal = 1'b1; i_dec_target = 32'hFFFF_FFF8;
    step();
    i_dec_jal = 1'b0;
    repeat (12) step();
    check32("wrap_seen", {31'b0, wrap_seen}, 32'h1);
    check32("wrap_nxt_pc", wrap_nxt, 32'h0);
    check32("wrap_addr", wrap_acc_next, 32'h0);

    // Mid-stream reset with two outstanding; stale responses during and after reset.
    mem_stall = 1;
    repeat (6) step();
    i_rst = 1'b1;
    mem_stall = 0;
    repeat (3) step();
    mq_addr.delete();
    mq_due.delete();
    i_rst = 1'b0;
    force_stale = 1;
    #1;
    check32("rerst_req", {31'b0, o_imem_req}, 32'h1);
    check32("rerst_addr", o_imem_addr, 32'h0);
    check32("rerst_vld", {31'b0, o_vld}, 32'h0);
    mark = consumed.size();
    repeat (10) step();
    check32("rerst_first_pc", consumed[mark], 32'h0);

    // Random phase.
    lat_min = 1; lat_max = 4; rsp_pct = 70;
    mark = consumed.size();
    repeat (1500) begin
      int r;
      i_imem_ready = ($urandom_range(99) < 75);
      i_hold       = ($urandom_range(99) < 25);
      r = int'($urandom_range(99));
      if (r < 3 || r == 6) begin
        i_ex_redirect = 1'b1;
        i_ex_target   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      end
      if ((r >= 3 && r < 6) || r == 6) begin
        i_dec_jal    = 1'b1;
        i_dec_target = $urandom() & 32'hFFFF_FFFC;
      end
      step();
      i_ex_redirect = 1'b0;
      i_dec_jal     = 1'b0;
    end
    check32("rand_progress", {31'b0, (consumed.size() - mark) > 200}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have ports, clock and reset first. Reset i_rst is synchronous and active-high; the clock is i_clk.
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_hold  in  1  decode stall; the IF/ID output is held
- i_ex_redirect  in  1  taken branch/jalr from EX
- i_ex_target  in  32  EX redirect target
- i_dec_jal  in  1  early jal detected in decode
- i_dec_target  in  32  jal target
- o_imem_req  out  1  fetch request
- o_imem_addr  out  32  fetch address
- i_imem_ready  in  1  imem accepts the request this cycle
- i_imem_rvalid  in  1  response valid; responses return in order
- i_imem_rdata  in  32  response instruction
- o_vld  out  1  instruction valid to decode
- o_inst  out  32  instruction to decode
- o_pc  out  32  PC of o_inst
- o_nxt_pc  out  32  o_pc+4
- o_flush  out  1  squash decode input this cycle

Function
REQ-003 SHALL hold fetch_pc. A request is accepted when o_imem_req & i_imem_ready; on acceptance fetch_pc <= fetch_pc+4, mod 2^32, wrapping at 32'hFFFFFFFC to 0.
REQ-004 SHALL drive o_imem_addr = fetch_pc.
REQ-005 SHALL assert o_imem_req only when all hold: not in reset; no redirect this cycle; outstanding + fifo_count < 2 (credit rule).
REQ-006 SHALL track outstanding (0..2): +1 on acceptance, -1 on i_imem_rvalid, unchanged when both occur in the same cycle.
REQ-007 SHALL keep a 2-entry PC queue of accepted addresses and pair each response with its head entry.
REQ-008 SHALL push non-discarded responses into a 2-entry output FIFO of {inst, pc}. The credit rule guarantees no overflow; a push into a full FIFO is a design error flagged by an assertion.
REQ-009 SHALL present the FIFO head combinationally:
- o_vld = !empty
- o_inst = head.inst, or 32'h00000033 when empty
- o_pc = head.pc
- o_nxt_pc = head.pc+4
REQ-010 SHALL pop the head when o_vld & !i_hold. A simultaneous push and pop leaves the count unchanged, and a response arriving at an empty FIFO is visible the next cycle (1-cycle rvalid-to-o_vld latency).
REQ-011 SHALL treat i_ex_redirect | i_dec_jal as a redirect, with i_ex_redirect taking priority. On a redirect:
- fetch_pc <= selected target
- output FIFO and PC queue cleared
- discard <= outstanding minus any rvalid in that cycle
- o_flush = 1 combinationally that cycle
REQ-012 SHALL drop a response that arrives in the redirect cycle, and SHALL drop and decrement discard for each response while discard > 0.
REQ-013 SHALL apply a redirect during i_hold and clear the FIFO regardless of the hold.
REQ-014 SHALL ignore i_imem_rvalid when outstanding == 0.

Reset
REQ-015 SHALL, while i_rst is high, set fetch_pc = RESET_ADDR and clear outstanding, discard, both FIFOs and the PC queue, and drive o_imem_req=0, o_vld=0, o_inst=32'h00000033, o_pc=0, o_nxt_pc=4, o_flush=0.
REQ-016 SHALL assert its first request in the first cycle after i_rst deasserts.
REQ-017 SHALL, on reset mid-operation, abandon in-flight requests; their late responses are ignored per REQ-014.

Verification
REQ-018 Streaming: RESET_ADDR=0, i_imem_ready=1, 1-cycle response, i_hold=0 -> o_pc sequence 0,4,8,C with o_vld continuously high after fill, and o_nxt_pc = o_pc+4.
REQ-019 Backpressure: i_hold=1 for 5 cycles with the FIFO full -> o_imem_req=0, o_inst/o_pc stable, no response lost; after release, order is preserved.
REQ-020 Redirect with 2 outstanding: i_ex_redirect=1, i_ex_target=32'h100 -> o_flush=1 that cycle; next 2 responses dropped; next o_vld has o_pc=32'h100.
REQ-021 Simultaneous i_ex_redirect (target 32'h200) and i_dec_jal (target 32'h300) -> fetch resumes at 32'h200.
REQ-022 Wrap: fetch_pc=32'hFFFFFFFC accepted -> next o_imem_addr=0, and the o_nxt_pc of that instruction is 0.
REQ-023 Mid-stream reset with 2 outstanding, responses delivered during and after reset -> o_vld=0, and the first request after reset is to RESET_ADDR.
